// File: rtl/pnc_req_arbiter_pkg.sv
// Shared types and constants for the PNC request arbiter.
package pnc_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, FLUSH} state_e;

  typedef enum logic {GNT_HOST, GNT_SWU} gnt_src_e;

  localparam logic [3:0]  TGT_SYNAPSE  = 4'h1;
  localparam logic [3:0]  TGT_SOMA     = 4'h2;
  localparam logic [3:0]  TGT_STDP     = 4'h3;
  localparam logic [15:0] PNC_NOP_ADDR = 16'h0000;

  function automatic logic tgt_valid(input logic [15:0] addr);
    return (addr[15:12] == TGT_SYNAPSE) || (addr[15:12] == TGT_SOMA) ||
           (addr[15:12] == TGT_STDP);
  endfunction

endpackage

// File: rtl/pnc_req_arbiter_if.sv
// Requester, flush and PNC command signals of the arbiter.
interface pnc_req_arbiter_if;
  logic        host_req;
  logic [15:0] host_addr;
  logic [31:0] host_data;
  logic        host_ack;
  logic        swu_req;
  logic [15:0] swu_addr;
  logic [7:0]  swu_data;
  logic        swu_ack;
  logic        flush_req;
  logic        flush_done;
  logic [15:0] pnc_iADDR;
  logic [31:0] pnc_W_DATA;
  logic        pnc_SWU_EN;
  logic [15:0] pnc_SWU_ADDR;
  logic [7:0]  pnc_SWU_DATA;
  logic        pnc_kill;
  logic        err_badtgt;
  logic        busy;

  modport slave (
    input  host_req, host_addr, host_data, swu_req, swu_addr, swu_data, flush_req,
    output host_ack, swu_ack, flush_done, pnc_iADDR, pnc_W_DATA, pnc_SWU_EN,
           pnc_SWU_ADDR, pnc_SWU_DATA, pnc_kill, err_badtgt, busy
  );

  modport master (
    output host_req, host_addr, host_data, swu_req, swu_addr, swu_data, flush_req,
    input  host_ack, swu_ack, flush_done, pnc_iADDR, pnc_W_DATA, pnc_SWU_EN,
           pnc_SWU_ADDR, pnc_SWU_DATA, pnc_kill, err_badtgt, busy
  );
endinterface

// File: rtl/pnc_req_arbiter_pick.sv
// Host/SWU selector: SWU wins ties until MAX_BURST consecutive SWU grants starve the host.
module pnc_arb_pick
  import pnc_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en_i,
  input  logic     clr_i,
  input  logic     host_req_i,
  input  logic     swu_req_i,
  output logic     gnt_valid_o,
  output gnt_src_e gnt_src_o
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    gnt_valid_o = en_i & (host_req_i | swu_req_i);
    gnt_src_o   = GNT_HOST;
    if (swu_req_i && (!host_req_i || cnt_q != MaxBurst)) begin
      gnt_src_o = GNT_SWU;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (en_i) begin
      if (!host_req_i || gnt_src_o == GNT_HOST) begin
        cnt_d = 4'd0;
      end else if (cnt_q != MaxBurst) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pnc_req_arbiter.sv
// PNC command-path scheduler: one transaction per slot, settle gap, and flush kill window.
module pnc_req_arbiter
  import pnc_arb_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned KILL_CYC   = 3
) (
  input logic               clk,
  input logic               rst,
  pnc_req_arbiter_if.slave  bus
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        bad_q, bad_d;
  logic        host_ack_q, host_ack_d;
  logic        swu_ack_q, swu_ack_d;
  logic        done_q, done_d;
  logic        kill_q, kill_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic [15:0] iaddr_q, iaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        swu_en_q, swu_en_d;
  logic [15:0] swu_addr_q, swu_addr_d;
  logic [7:0]  swu_data_q, swu_data_d;

  logic        gnt_valid;
  gnt_src_e    gnt_src;
  logic        in_idle;
  logic        sel_ok;

  assign in_idle = (state_q == IDLE);
  assign sel_ok  = tgt_valid((gnt_src == GNT_HOST) ? bus.host_addr : bus.swu_addr);

  pnc_arb_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .clk         (clk),
    .rst         (rst),
    .en_i        (in_idle & ~bus.flush_req),
    .clr_i       (in_idle & bus.flush_req),
    .host_req_i  (bus.host_req),
    .swu_req_i   (bus.swu_req),
    .gnt_valid_o (gnt_valid),
    .gnt_src_o   (gnt_src)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bad_d      = bad_q;
    host_ack_d = 1'b0;
    swu_ack_d  = 1'b0;
    done_d     = 1'b0;
    kill_d     = 1'b0;
    err_d      = 1'b0;
    iaddr_d    = PNC_NOP_ADDR;
    wdata_d    = 32'h0;
    swu_en_d   = 1'b0;
    swu_addr_d = PNC_NOP_ADDR;
    swu_data_d = 8'h0;

    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = FLUSH;
          kill_d  = 1'b1;
          done_d  = (KILL_CYC == 1);
          cnt_d   = 4'(KILL_CYC - 1);
        end else if (gnt_valid) begin
          // Bad-target grants still pass through ISSUE so the held request is not resampled.
          state_d = ISSUE;
          bad_d   = ~sel_ok;
          err_d   = ~sel_ok;
          if (gnt_src == GNT_HOST) begin
            host_ack_d = 1'b1;
            if (sel_ok) begin
              iaddr_d = bus.host_addr;
              wdata_d = bus.host_data;
            end
          end else begin
            swu_ack_d = 1'b1;
            if (sel_ok) begin
              swu_en_d   = 1'b1;
              swu_addr_d = bus.swu_addr;
              swu_data_d = bus.swu_data;
            end
          end
        end
      end
      ISSUE: begin
        state_d = bad_q ? IDLE : SETTLE;
        cnt_d   = 4'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          kill_d = 1'b1;
          done_d = (cnt_q == 4'd1);
          cnt_d  = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      bad_q      <= 1'b0;
      host_ack_q <= 1'b0;
      swu_ack_q  <= 1'b0;
      done_q     <= 1'b0;
      kill_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      iaddr_q    <= 16'h0;
      wdata_q    <= 32'h0;
      swu_en_q   <= 1'b0;
      swu_addr_q <= 16'h0;
      swu_data_q <= 8'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      host_ack_q <= host_ack_d;
      swu_ack_q  <= swu_ack_d;
      done_q     <= done_d;
      kill_q     <= kill_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      iaddr_q    <= iaddr_d;
      wdata_q    <= wdata_d;
      swu_en_q   <= swu_en_d;
      swu_addr_q <= swu_addr_d;
      swu_data_q <= swu_data_d;
    end
  end

  assign bus.host_ack     = host_ack_q;
  assign bus.swu_ack      = swu_ack_q;
  assign bus.flush_done   = done_q;
  assign bus.pnc_kill     = kill_q;
  assign bus.err_badtgt   = err_q;
  assign bus.busy         = busy_q;
  assign bus.pnc_iADDR    = iaddr_q;
  assign bus.pnc_W_DATA   = wdata_q;
  assign bus.pnc_SWU_EN   = swu_en_q;
  assign bus.pnc_SWU_ADDR = swu_addr_q;
  assign bus.pnc_SWU_DATA = swu_data_q;

endmodule

// File: tb/tb_pnc_req_arbiter.sv
// Directed bench for pnc_req_arbiter with default parameters.
module tb_pnc_req_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pnc_req_arbiter_if bus ();

  pnc_req_arbiter #(
    .SETTLE_CYC (2),
    .MAX_BURST  (4),
    .KILL_CYC   (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] pnc_drive();
    return {7'h0, bus.pnc_SWU_EN, bus.pnc_SWU_DATA, bus.pnc_SWU_ADDR, bus.pnc_iADDR,
            bus.pnc_W_DATA};
  endfunction

  function automatic logic [79:0] all_outs();
    return {1'b0, bus.host_ack, bus.swu_ack, bus.flush_done, bus.pnc_kill, bus.err_badtgt,
            bus.busy, bus.pnc_SWU_EN, bus.pnc_SWU_DATA, bus.pnc_SWU_ADDR, bus.pnc_iADDR,
            bus.pnc_W_DATA};
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.host_req  = 1'b0;
    bus.host_addr = 16'h0;
    bus.host_data = 32'h0;
    bus.swu_req   = 1'b0;
    bus.swu_addr  = 16'h0;
    bus.swu_data  = 8'h0;
    bus.flush_req = 1'b0;
    tick();
    tick();
    chk("reset_outs", all_outs(), 80'h0);

    // Single host request
    rst = 1'b0;
    bus.host_req  = 1'b1;
    bus.host_addr = 16'h1005;
    bus.host_data = 32'hDEADBEEF;
    tick();
    bus.host_req = 1'b0;
    chk("h1_acks", {78'h0, bus.host_ack, bus.swu_ack}, 80'h2);
    chk("h1_drive", pnc_drive(), {7'h0, 1'b0, 8'h00, 16'h0000, 16'h1005, 32'hDEADBEEF});
    chk("h1_busy_err", {78'h0, bus.busy, bus.err_badtgt}, 80'h2);
    tick();
    chk("h1_c2_ack", {79'h0, bus.host_ack}, 80'h0);
    chk("h1_c2_idle", pnc_drive(), 80'h0);
    chk("h1_c2_busy", {79'h0, bus.busy}, 80'h1);
    tick();
    chk("h1_c3_idle", pnc_drive(), 80'h0);
    chk("h1_c3_busy", {79'h0, bus.busy}, 80'h1);
    tick();
    chk("h1_c4_busy", {79'h0, bus.busy}, 80'h0);

    // Single SWU request
    bus.swu_req  = 1'b1;
    bus.swu_addr = 16'h2010;
    bus.swu_data = 8'h7F;
    tick();
    bus.swu_req = 1'b0;
    chk("s1_acks", {78'h0, bus.host_ack, bus.swu_ack}, 80'h1);
    chk("s1_drive", pnc_drive(), {7'h0, 1'b1, 8'h7F, 16'h2010, 16'h0000, 32'h0});
    tick();
    tick();
    tick();

    // Both requesters held: SWU x4 then host, one issue every 4 cycles
    bus.host_req  = 1'b1;
    bus.host_addr = 16'h2AAA;
    bus.host_data = 32'h12345678;
    bus.swu_req   = 1'b1;
    bus.swu_addr  = 16'h3055;
    bus.swu_data  = 8'h5A;
    for (int c = 1; c <= 40; c++) begin
      logic exp_h;
      logic exp_s;
      tick();
      exp_h = 1'b0;
      exp_s = 1'b0;
      if ((c % 4) == 1) begin
        exp_h = (((c - 1) / 4) % 5) == 4;
        exp_s = ~exp_h;
      end
      chk($sformatf("fair_c%0d", c), {77'h0, bus.host_ack, bus.swu_ack, bus.pnc_SWU_EN},
          {77'h0, exp_h, exp_s, exp_s});
      if (c == 40) begin
        bus.host_req = 1'b0;
        bus.swu_req  = 1'b0;
      end
    end

    // Invalid host target
    bus.host_req  = 1'b1;
    bus.host_addr = 16'h9000;
    bus.host_data = 32'h11111111;
    tick();
    bus.host_req = 1'b0;
    chk("bad_ack_err", {78'h0, bus.host_ack, bus.err_badtgt}, 80'h3);
    chk("bad_drive", pnc_drive(), 80'h0);
    bus.swu_req  = 1'b1;
    bus.swu_addr = 16'h1234;
    bus.swu_data = 8'h33;
    tick();
    chk("bad_c2_quiet", {78'h0, bus.swu_ack, bus.err_badtgt}, 80'h0);
    chk("bad_c2_idle", pnc_drive(), 80'h0);
    tick();
    bus.swu_req = 1'b0;
    chk("bad_c3_swu", {78'h0, bus.swu_ack, bus.err_badtgt}, 80'h2);
    chk("bad_c3_drive", pnc_drive(), {7'h0, 1'b1, 8'h33, 16'h1234, 16'h0000, 32'h0});
    tick();
    tick();
    tick();

    // Flush beats a simultaneous host request
    bus.flush_req = 1'b1;
    bus.host_req  = 1'b1;
    bus.host_addr = 16'h3001;
    bus.host_data = 32'hCAFEF00D;
    tick();
    chk("fl_c1", {76'h0, bus.pnc_kill, bus.flush_done, bus.host_ack, bus.busy}, 80'h9);
    tick();
    chk("fl_c2", {76'h0, bus.pnc_kill, bus.flush_done, bus.host_ack, bus.busy}, 80'h9);
    tick();
    chk("fl_c3", {76'h0, bus.pnc_kill, bus.flush_done, bus.host_ack, bus.busy}, 80'hD);
    bus.flush_req = 1'b0;
    tick();
    chk("fl_c4", {77'h0, bus.pnc_kill, bus.flush_done, bus.host_ack}, 80'h0);
    tick();
    bus.host_req = 1'b0;
    chk("fl_c5_ack", {79'h0, bus.host_ack}, 80'h1);
    chk("fl_c5_drive", pnc_drive(), {7'h0, 1'b0, 8'h00, 16'h0000, 16'h3001, 32'hCAFEF00D});
    tick();
    tick();
    tick();

    // Reset during SETTLE
    bus.swu_req  = 1'b1;
    bus.swu_addr = 16'h1100;
    bus.swu_data = 8'h44;
    tick();
    bus.swu_req = 1'b0;
    chk("rs_c1_ack", {79'h0, bus.swu_ack}, 80'h1);
    tick();
    rst = 1'b1;
    tick();
    chk("rs_outs", all_outs(), 80'h0);
    rst = 1'b0;
    bus.host_req  = 1'b1;
    bus.host_addr = 16'h2002;
    bus.host_data = 32'h0BADF00D;
    tick();
    bus.host_req = 1'b0;
    chk("rs_host_ack", {79'h0, bus.host_ack}, 80'h1);
    chk("rs_host_drive", pnc_drive(),
        {7'h0, 1'b0, 8'h00, 16'h0000, 16'h2002, 32'h0BADF00D});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
